// File: rtl/imem_loader.sv
// Program loader: parses a byte stream (count header, 4-byte bundles, XOR checksum)
// and writes 32-bit VLIW bundles to instruction memory, holding the core until done.
module imem_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_BODY,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_cnt_lo;
    logic [7:0]        r_xor;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_idx;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_asm;

    logic              w_accept;
    logic [15:0]       w_n;
    logic              w_oversize;
    logic              w_last_byte;
    logic              w_last_bundle;

    assign w_accept      = in_valid && in_ready;
    assign w_n           = {in_data, r_cnt_lo};
    assign w_oversize    = 32'(w_n) > DEPTH;
    assign w_last_byte   = (r_byte_idx == 2'd3);
    assign w_last_bundle = (r_idx == (r_count - CNT_W'(1)));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_HDR0;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HDR0: begin
                if (w_accept) begin
                    w_next = S_HDR1;
                end
            end
            S_HDR1: begin
                if (w_accept) begin
                    if (w_oversize) begin
                        w_next = S_ERR;
                    end else if (w_n == 16'd0) begin
                        w_next = S_CSUM;
                    end else begin
                        w_next = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (w_accept && w_last_byte && w_last_bundle) begin
                    w_next = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_next = (in_data == r_xor) ? S_DONE : S_ERR;
                end
            end
            S_DONE:  w_next = S_DONE;
            S_ERR:   w_next = S_ERR;
            default: w_next = S_HDR0;
        endcase
    end

    // Status outputs registered from the next state so they move on the accepting edge
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            core_hold <= 1'b1;
        end else begin
            in_ready  <= (w_next != S_DONE) && (w_next != S_ERR);
            done      <= (w_next == S_DONE);
            error     <= (w_next == S_ERR);
            core_hold <= (w_next != S_DONE);
        end
    end

    // Header capture, bundle assembly, write issue and running checksum
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_lo   <= 8'd0;
            r_xor      <= 8'd0;
            r_count    <= '0;
            r_idx      <= '0;
            r_byte_idx <= 2'd0;
            r_asm      <= 24'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            if (w_accept) begin
                if (r_state != S_CSUM) begin
                    r_xor <= r_xor ^ in_data;
                end
                case (r_state)
                    S_HDR0: r_cnt_lo <= in_data;
                    S_HDR1: r_count  <= CNT_W'(w_n);
                    S_BODY: begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (w_last_byte) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= r_idx[ADDR_W-1:0];
                            imem_wdata <= {in_data, r_asm};
                            r_idx      <= r_idx + CNT_W'(1);
                        end else begin
                            // New byte enters at the top so b0 ends up in the low lane
                            r_asm <= {in_data, r_asm[23:8]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random streams against a
// stream-level reference model.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int          DEPTH  = 2 ** ADDR_W;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  q[$];
    logic [39:0] wq[$];

    int m_n;
    bit m_over;
    int m_cpos;
    bit m_ok;
    int m_acc;

    always @(negedge clk) begin
        if (!reset && imem_we) wq.push_back({imem_addr, imem_wdata});
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: derive expectations for the whole stream in q
    task automatic model();
        logic [7:0] x;
        m_n    = (q.size() >= 2) ? int'({q[1], q[0]}) : 0;
        m_over = (m_n > DEPTH);
        m_cpos = 2 + 4 * m_n;
        x = 8'h00;
        for (int i = 0; i < m_cpos && i < q.size(); i++) x = x ^ q[i];
        m_ok  = (m_cpos < q.size()) && (q[m_cpos] == x);
        m_acc = m_over ? 2 : ((q.size() < m_cpos + 1) ? q.size() : m_cpos + 1);
    endtask

    function automatic logic [31:0] bundle(input int k);
        return {q[2+4*k+3], q[2+4*k+2], q[2+4*k+1], q[2+4*k]};
    endfunction

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_in_ready",  64'(in_ready),   64'd1);
        chk("rst_we",        64'(imem_we),    64'd0);
        chk("rst_addr",      64'(imem_addr),  64'd0);
        chk("rst_wdata",     64'(imem_wdata), 64'd0);
        chk("rst_core_hold", 64'(core_hold),  64'd1);
        chk("rst_done",      64'(done),       64'd0);
        chk("rst_error",     64'(error),      64'd0);
    endtask

    task automatic set_q(input logic [7:0] b[]);
        q.delete();
        foreach (b[i]) q.push_back(b[i]);
    endtask

    // Drive q byte by byte; check per-byte effects and optionally the final outcome
    task automatic run_stream(input int max_idle, input bit check_final);
        int p = 0;
        foreach (q[i]) begin
            bit acc = 1'b0;
            repeat ($urandom_range(0, max_idle)) @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_data  = q[i];
            for (int w = 0; w < 3 && !acc; w++) begin
                @(negedge clk);
                if (in_ready) acc = 1'b1;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            if (acc) begin
                bit is_b3  = !m_over && p >= 2 && p < m_cpos && ((p - 2) % 4 == 3);
                bit term   = (m_over && p == 1) || (!m_over && p == m_cpos);
                bit e_done = !m_over && p == m_cpos && m_ok;
                bit e_err  = term && !e_done;
                chk("byte_we", 64'(imem_we), 64'(is_b3));
                if (is_b3) begin
                    chk("byte_addr",  64'(imem_addr),  64'((p - 2) / 4 % DEPTH));
                    chk("byte_wdata", 64'(imem_wdata), 64'(bundle((p - 2) / 4)));
                end
                if (term) begin
                    chk("term_done",      64'(done),      64'(e_done));
                    chk("term_error",     64'(error),     64'(e_err));
                    chk("term_core_hold", 64'(core_hold), 64'(!e_done));
                    chk("term_in_ready",  64'(in_ready),  64'd0);
                end else begin
                    chk("mid_in_ready",  64'(in_ready),  64'd1);
                    chk("mid_core_hold", 64'(core_hold), 64'd1);
                end
                p++;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        if (check_final) begin
            chk("acc_count", 64'(p), 64'(m_acc));
            chk("n_writes", 64'(wq.size()), 64'(m_over ? 0 : m_n));
            for (int k = 0; k < wq.size() && k < m_n && !m_over; k++) begin
                chk("wr_addr", 64'(wq[k][39:32]), 64'(k % DEPTH));
                chk("wr_data", 64'(wq[k][31:0]),  64'(bundle(k)));
            end
            chk("fin_done",      64'(done),      64'(!m_over && m_ok));
            chk("fin_error",     64'(error),     64'(m_over || !m_ok));
            chk("fin_core_hold", 64'(core_hold), 64'(m_over || !m_ok));
            chk("fin_we",        64'(imem_we),   64'd0);
        end
    endtask

    task automatic run_test(input int max_idle);
        do_reset();
        wq.delete();
        model();
        run_stream(max_idle, 1'b1);
    endtask

    initial begin
        logic [7:0] x;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Test 1: two bundles, good checksum
        set_q('{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55, 8'h8A});
        run_test(0);

        // Test 2: bad checksum
        set_q('{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55, 8'h8B});
        run_test(0);

        // Test 3: empty program
        set_q('{8'h00, 8'h00, 8'h00});
        run_test(0);

        // Test 4: oversize count, trailing bytes must be refused
        set_q('{8'h01, 8'h01, 8'hAA, 8'hBB});
        run_test(0);

        // Test 5: test 1 with idle gaps and extra bytes after the checksum
        set_q('{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55, 8'h8A,
                8'h12, 8'h34});
        run_test(3);

        // Test 6: reset in the middle of the first bundle, then a full load
        do_reset();
        wq.delete();
        set_q('{8'h02, 8'h00, 8'h44, 8'h33});
        model();
        run_stream(0, 1'b0);
        do_reset();
        set_q('{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55, 8'h8A});
        model();
        run_stream(0, 1'b1);

        // Full-depth load: N = 2**ADDR_W is legal
        q.delete();
        q.push_back(8'(DEPTH));
        q.push_back(8'(DEPTH >> 8));
        for (int i = 0; i < 4 * DEPTH; i++) q.push_back(8'($urandom));
        x = 8'h00;
        foreach (q[i]) x = x ^ q[i];
        q.push_back(x);
        run_test(0);

        // Random streams with random gaps, occasional checksum corruption and trailers
        for (int t = 0; t < 12; t++) begin
            int n = (t == 11) ? 257 + int'($urandom_range(0, 600)) : int'($urandom_range(0, 6));
            q.delete();
            q.push_back(8'(n));
            q.push_back(8'(n >> 8));
            if (n <= DEPTH) begin
                for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
                x = 8'h00;
                foreach (q[i]) x = x ^ q[i];
                if ($urandom_range(0, 3) == 0) x = x ^ (8'h01 << $urandom_range(0, 7));
                q.push_back(x);
            end
            repeat ($urandom_range(0, 2)) q.push_back(8'($urandom));
            run_test(2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes VLIW instruction bundles into instruction memory, the write-side counterpart of the IF stage's bundle fetch. It accepts a byte stream over a valid/ready handshake, assembles 32-bit bundles (ALU slot + MEM slot), and writes them to consecutive instruction-memory words. It verifies a trailing XOR checksum and holds the core in reset until a load completes cleanly.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width; depth = 2**ADDR_W bundles.

Ports:
- clk  in  1  core clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  host byte valid.
- in_ready  out  1  loader can accept a byte.
- in_data  in  8  host byte.
- imem_we  out  1  instruction-memory write strobe, one cycle per bundle.
- imem_addr  out  ADDR_W  bundle word address.
- imem_wdata  out  32  bundle; [15:0] = ALU-slot instr, [31:16] = MEM-slot instr.
- core_hold  out  1  drives core reset; high until load succeeds.
- done  out  1  load complete, checksum matched (sticky).
- error  out  1  load failed (sticky).

One clock; reset is synchronous and active-high. The ports are named clk and reset.

## Operation
- Byte accepted on a rising edge with in_valid && in_ready.
- Stream format:
  - CNT_LO, CNT_HI: 16-bit bundle count N, little-endian.
  - N bundles of 4 bytes: b0 = alu[7:0], b1 = alu[15:8], b2 = mem[7:0], b3 = mem[15:8].
  - One checksum byte = XOR of all preceding bytes, header included.
- States:
  - HDR0: accept CNT_LO -> HDR1.
  - HDR1: accept CNT_HI. N > 2**ADDR_W -> ERR. N == 0 -> CSUM. Else -> BODY.
  - BODY: 2-bit byte index, 0..3. Bytes shift into an assembly register. On b3, a write is issued. After bundle N-1 -> CSUM.
  - CSUM: accept byte. Equal to running XOR -> DONE, else -> ERR.
  - DONE: done=1, core_hold=0.
  - ERR: error=1, core_hold=1.
  - DONE and ERR are sticky until reset.
- in_ready = 1 in HDR0/HDR1/BODY/CSUM; 0 in DONE/ERR.
- Bundle index counter is ADDR_W+1 bits wide, so N = 2**ADDR_W is legal; imem_addr takes its low ADDR_W bits.
- Running XOR register is 8 bits, cleared on reset, updated on every accepted byte except the checksum byte.
- Bundles already written before an ERR are not rolled back.

## Timing
- Reset values:
  - State HDR0, so in_ready=1 the cycle after reset deasserts.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - core_hold=1, done=0, error=0.
  - Byte index=0, bundle count=0, XOR=0.
- Write latency: b3 accepted at edge k -> imem_we=1 in cycle k..k+1, with imem_addr = bundle index and imem_wdata = {b3,b2,b1,b0}; imem_we=0 next cycle.
- imem_addr/imem_wdata hold their last values between writes.
- done/error/core_hold change on the edge that accepts the checksum byte (or CNT_HI for an oversize N).
- Full rate is 1 byte/cycle with no bubbles; loader never deasserts in_ready mid-load. Idle cycles (in_valid=0) change nothing.
- Reset during any state, including the write cycle: on the next edge, everything returns to reset values and imem_we=0. The partially assembled bundle is discarded.

## Test plan
- Bytes 02 00 44 33 22 11 88 77 66 55 8A, back-to-back. Required:
  - write addr0 = 0x11223344, addr1 = 0x55667788, each imem_we one cycle;
  - done=1, core_hold=0, in_ready=0 after the checksum byte.
- Same stream with checksum 8B. Required: both writes occur; error=1, done=0, core_hold=1, in_ready=0.
- Bytes 00 00 00 (N=0). Required: no imem_we; done=1 after third byte.
- Bytes 01 01 (N=257, ADDR_W=8). Required: error=1 on the edge accepting the second byte; no writes; further bytes ignored.
- Test 1 stream with random 0-3 idle cycles between bytes. Required: identical writes and done. Extra bytes after DONE are not accepted.
- Reset pulse after 02 00 44 33, then the full test 1 stream. Required: no write from the aborted bundle; writes addr0 = 0x11223344, addr1 = 0x55667788; done=1.
